clksel_ctrl: RTL

- Clock-selection sequencer directly upstream of the PHI2 clock-switch stage.
- Decides, per CPU access, whether the CPU runs on the high-speed divided clock or the host (motherboard) clock. Drives that stage's hsclk_sel and cpuclk_div_sel inputs.
- Consumes its hsclk_selected / lsclk_selected feedback and produces a stall indication while a switch is in flight.
- Enforces an idle-hold on the host clock, a glitch-safe divider update and an acknowledge timeout.

---
 rtl/clksel_pkg.sv | 24 ++
 rtl/clksel_ctrl_if.sv | 22 ++
 rtl/sync2.sv | 24 ++
 rtl/clksel_ctrl.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/clksel_pkg.sv
// Shared types and constants for the clock-selection sequencer.
package clksel_pkg;

  localparam int unsigned HOLD_W = 8;
  localparam int unsigned TO_W   = 10;

  typedef enum logic [2:0] {
    StLsRun  = 3'd0,
    StLsHold = 3'd1,
    StToHs   = 3'd2,
    StHsRun  = 3'd3,
    StToLs   = 3'd4
  } state_e;

  localparam logic [1:0] DIV_1 = 2'b00;
  localparam logic [1:0] DIV_2 = 2'b01;
  localparam logic [1:0] DIV_3 = 2'b10;

  // Divider code may only change while the CPU runs from the host clock.
  function automatic logic is_ls_state(state_e s);
    return (s == StLsRun) || (s == StLsHold);
  endfunction

endpackage

// File: rtl/clksel_ctrl_if.sv
// CPU-access, divider and switch-stage signals of the clock-selection sequencer.
interface clksel_ctrl_if;
  logic       acc_valid;
  logic       acc_host;
  logic [1:0] div_req;
  logic       hsclk_selected;
  logic       lsclk_selected;
  logic       hsclk_sel;
  logic [1:0] cpuclk_div_sel;
  logic       stall;
  logic       sw_err;

  modport master (
    output acc_valid, acc_host, div_req, hsclk_selected, lsclk_selected,
    input  hsclk_sel, cpuclk_div_sel, stall, sw_err
  );

  modport slave (
    input  acc_valid, acc_host, div_req, hsclk_selected, lsclk_selected,
    output hsclk_sel, cpuclk_div_sel, stall, sw_err
  );
endinterface

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level, cleared by a synchronous reset.
module sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/clksel_ctrl.sv
// Chooses high-speed or host clock per CPU access and sequences the switch stage,
// stalling the CPU while a switch is in flight and flagging acknowledge timeouts.
module clksel_ctrl
  import clksel_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [1:0]  DIV_RST        = DIV_1
) (
  input logic          hsclk_in,
  input logic          rst,
  clksel_ctrl_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  logic w_hs_ack_s;
  logic w_ls_ack_s;

  sync2 u_sync_hs (
    .i_clk (hsclk_in),
    .i_rst (rst),
    .i_d   (bus.hsclk_selected),
    .o_q   (w_hs_ack_s)
  );

  sync2 u_sync_ls (
    .i_clk (hsclk_in),
    .i_rst (rst),
    .i_d   (bus.lsclk_selected),
    .o_q   (w_ls_ack_s)
  );

  state_e            r_state;
  state_e            w_state_d;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_d;
  logic [TO_W-1:0]   r_to;
  logic [TO_W-1:0]   w_to_d;
  logic              r_sw_err;
  logic              w_sw_err_d;
  logic              r_hsclk_sel;
  logic              w_hsclk_sel_d;
  logic [1:0]        r_div;
  logic [1:0]        w_div_d;
  logic              w_stall;

  // Overlapping (both high) or absent (both low) acks never complete a switch.
  logic w_hs_done;
  logic w_ls_done;
  logic w_host_acc;
  logic w_fast_acc;
  logic w_to_hit;

  assign w_hs_done  = w_hs_ack_s & ~w_ls_ack_s;
  assign w_ls_done  = w_ls_ack_s & ~w_hs_ack_s;
  assign w_host_acc = bus.acc_valid & bus.acc_host;
  assign w_fast_acc = bus.acc_valid & ~bus.acc_host;
  assign w_to_hit   = (r_to == TO_LAST);

  always_comb begin
    w_state_d  = r_state;
    w_hold_d   = r_hold;
    w_to_d     = r_to;
    w_sw_err_d = r_sw_err;
    w_stall    = 1'b0;
    unique case (r_state)
      StLsRun: begin
        if (w_fast_acc) begin
          w_hold_d  = HOLD_LOAD;
          w_state_d = StLsHold;
        end
      end
      StLsHold: begin
        if (w_host_acc) begin
          w_state_d = StLsRun;
        end else if (r_hold == '0) begin
          w_state_d = StToHs;
        end else begin
          w_hold_d = r_hold - 8'd1;
        end
      end
      StToHs: begin
        w_stall = ~w_hs_done;
        if (w_hs_done) begin
          w_state_d = StHsRun;
          w_to_d    = '0;
        end else if (w_to_hit) begin
          w_sw_err_d = 1'b1;
          w_state_d  = StLsRun;
          w_to_d     = '0;
        end else begin
          w_to_d = r_to + 10'd1;
        end
      end
      StHsRun: begin
        // The access that forces the switch must be held from its own cycle.
        if (w_host_acc) begin
          w_stall   = 1'b1;
          w_state_d = StToLs;
        end
      end
      StToLs: begin
        w_stall = ~w_ls_done;
        if (w_ls_done) begin
          w_state_d = StLsRun;
          w_to_d    = '0;
        end else if (w_to_hit) begin
          w_sw_err_d = 1'b1;
          w_state_d  = StLsRun;
          w_to_d     = '0;
        end else begin
          w_to_d = r_to + 10'd1;
        end
      end
      default: begin
        w_state_d = StLsRun;
        w_to_d    = '0;
      end
    endcase
  end

  // Registered select keeps the switch-stage input free of decode glitches.
  assign w_hsclk_sel_d = (w_state_d == StToHs) || (w_state_d == StHsRun);
  assign w_div_d       = (is_ls_state(r_state) && !w_hs_ack_s) ? bus.div_req : r_div;

  always_ff @(posedge hsclk_in) begin
    if (rst) begin
      r_state     <= StLsRun;
      r_hold      <= HOLD_LOAD;
      r_to        <= '0;
      r_sw_err    <= 1'b0;
      r_hsclk_sel <= 1'b0;
      r_div       <= DIV_RST;
    end else begin
      r_state     <= w_state_d;
      r_hold      <= w_hold_d;
      r_to        <= w_to_d;
      r_sw_err    <= w_sw_err_d;
      r_hsclk_sel <= w_hsclk_sel_d;
      r_div       <= w_div_d;
    end
  end

  assign bus.hsclk_sel      = r_hsclk_sel;
  assign bus.cpuclk_div_sel = r_div;
  assign bus.stall          = w_stall;
  assign bus.sw_err         = r_sw_err;

endmodule
